// File: rtl/icache_axi_rd_bridge_if.sv
// AXI4 read-only channel bundle (AR + R) between the icache refill bridge
// and the memory-side slave.
interface icache_axi_rd_bridge_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Icache refill read bridge: takes one cache read request, issues it as a
// single AXI4 INCR read burst and streams the returned beats back, one cycle late.
module icache_axi_rd_bridge #(
  parameter int          ID_WIDTH = 4,
  parameter int unsigned AXI_ID   = 0
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        rd_req,
  input  logic [2:0]  rd_type,
  input  logic [31:0] rd_addr,
  output logic        rd_rdy,

  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] ret_data,
  output logic        err,

  icache_axi_rd_bridge_if.master axi
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  localparam logic [2:0] TYPE_BYTE = 3'd0;
  localparam logic [2:0] TYPE_HALF = 3'd1;
  localparam logic [2:0] TYPE_WORD = 3'd2;
  localparam logic [2:0] TYPE_LINE = 3'd4;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_addr;
  logic [2:0]  r_type;
  logic [1:0]  r_beat_cnt;
  logic        r_beat_ovf;
  logic        r_ret_valid;
  logic        r_ret_last;
  logic [31:0] r_ret_data;
  logic        r_err;

  logic [2:0]  w_norm_type;
  logic        w_is_line;
  logic [1:0]  w_last_idx;
  logic        w_accept;
  logic        w_beat;
  logic        w_at_last;
  logic        w_done;
  logic        w_beat_err;
  logic        w_rid_unused;

  // The R channel ID is not checked: only one transaction is ever in flight.
  assign w_rid_unused = ^axi.rid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_norm_type = TYPE_WORD;
    case (rd_type)
      TYPE_BYTE: w_norm_type = TYPE_BYTE;
      TYPE_HALF: w_norm_type = TYPE_HALF;
      TYPE_LINE: w_norm_type = TYPE_LINE;
      default:   w_norm_type = TYPE_WORD;
    endcase
  end

  assign w_is_line  = r_type[2];
  assign w_last_idx = w_is_line ? 2'd3 : 2'd0;

  assign w_accept = rd_req && rd_rdy;
  assign w_beat   = (r_state == S_R) && axi.rvalid;

  // r_beat_ovf marks that the final expected beat came without rlast; any
  // further beat is an overrun and terminates the transaction on its own.
  assign w_at_last  = !r_beat_ovf && (r_beat_cnt == w_last_idx);
  assign w_done     = axi.rlast || r_beat_ovf;
  assign w_beat_err = w_beat && ((axi.rresp != 2'b00) ||
                                 (axi.rlast && !w_at_last) ||
                                 r_beat_ovf);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    rd_rdy       = 1'b0;
    axi.arvalid  = 1'b0;
    axi.rready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        rd_rdy = 1'b1;
        if (w_accept) w_next_state = S_AR;
      end
      S_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) w_next_state = S_R;
      end
      S_R: begin
        // The cache return path cannot stall, so R is always accepted.
        axi.rready = 1'b1;
        if (w_beat && w_done) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_type      <= '0;
      r_beat_cnt  <= '0;
      r_beat_ovf  <= 1'b0;
      r_ret_valid <= 1'b0;
      r_ret_last  <= 1'b0;
      r_ret_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_ret_valid <= w_beat;
      r_ret_last  <= w_beat && w_done;

      if (w_accept) begin
        r_addr     <= rd_addr;
        r_type     <= w_norm_type;
        r_beat_cnt <= '0;
        r_beat_ovf <= 1'b0;
      end

      if (w_beat) begin
        r_ret_data <= axi.rdata;
        r_beat_cnt <= r_beat_cnt + 2'd1;
        if (w_at_last && !axi.rlast) r_beat_ovf <= 1'b1;
      end

      if (w_beat_err) r_err <= 1'b1;
    end
  end

  assign axi.arid    = AXI_ID[ID_WIDTH-1:0];
  assign axi.araddr  = w_is_line ? {r_addr[31:4], 4'b0000} : r_addr;
  assign axi.arlen   = {6'd0, w_last_idx};
  assign axi.arsize  = w_is_line ? 3'd2 : {1'b0, r_type[1:0]};
  assign axi.arburst = 2'b01;

  assign ret_valid = r_ret_valid;
  assign ret_last  = r_ret_last;
  assign ret_data  = r_ret_data;
  assign err       = r_err;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: the bench plays the AXI slave and
// the cache, checking each cycle against hand-computed values.
module tb_icache_axi_rd_bridge;

  logic        clock;
  logic        reset;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
  logic        err;

  int n_checks = 0;
  int n_errs   = 0;

  icache_axi_rd_bridge_if #(.ID_WIDTH(4)) axi ();

  icache_axi_rd_bridge #(.ID_WIDTH(4), .AXI_ID(0)) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .err       (err),
    .axi       (axi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] t, input logic [31:0] a);
    rd_req  = 1'b1;
    rd_type = t;
    rd_addr = a;
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic ar_accept();
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic [1:0] resp);
    axi.rvalid = 1'b1;
    axi.rdata  = d;
    axi.rlast  = l;
    axi.rresp  = resp;
    tick();
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    rd_req      = 1'b0;
    rd_type     = 3'd0;
    rd_addr     = 32'h0;
    axi.arready = 1'b0;
    axi.rid     = 4'h0;
    axi.rdata   = 32'h0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_rd_rdy",    rd_rdy,      1);
    check("rst_arvalid",   axi.arvalid, 0);
    check("rst_rready",    axi.rready,  0);
    check("rst_ret_valid", ret_valid,   0);
    check("rst_ret_last",  ret_last,    0);
    check("rst_ret_data",  ret_data,    0);
    check("rst_err",       err,         0);

    // Line read, arready after 2 cycles, four contiguous beats
    issue(3'd4, 32'h1C00_0124);
    check("line_arvalid", axi.arvalid, 1);
    check("line_rd_rdy",  rd_rdy,      0);
    check("line_araddr",  axi.araddr,  32'h1C00_0120);
    check("line_arlen",   axi.arlen,   3);
    check("line_arsize",  axi.arsize,  2);
    check("line_arburst", axi.arburst, 1);
    check("line_arid",    axi.arid,    0);
    tick();
    check("line_arvalid_hold", axi.arvalid, 1);
    check("line_araddr_hold",  axi.araddr,  32'h1C00_0120);
    ar_accept();
    check("line_arvalid_drop", axi.arvalid, 0);
    check("line_rready",       axi.rready,  1);
    check("line_no_early_ret", ret_valid,   0);
    for (int i = 0; i < 4; i++) begin
      beat(32'hA0 + 32'(i), (i == 3), 2'b00);
      check($sformatf("line_ret_valid%0d", i), ret_valid, 1);
      check($sformatf("line_ret_data%0d", i),  ret_data,  32'hA0 + 32'(i));
      check($sformatf("line_ret_last%0d", i),  ret_last,  (i == 3) ? 1 : 0);
    end
    check("line_rd_rdy_after", rd_rdy,     1);
    check("line_rready_after", axi.rready, 0);
    tick();
    check("line_ret_valid_end", ret_valid, 0);
    check("line_err",           err,       0);

    // Word read on a zero-wait slave
    issue(3'd2, 32'h8000_0004);
    check("word_arvalid", axi.arvalid, 1);
    check("word_araddr",  axi.araddr,  32'h8000_0004);
    check("word_arlen",   axi.arlen,   0);
    check("word_arsize",  axi.arsize,  2);
    ar_accept();
    beat(32'hDEAD_BEEF, 1'b1, 2'b00);
    check("word_ret_valid", ret_valid, 1);
    check("word_ret_last",  ret_last,  1);
    check("word_ret_data",  ret_data,  32'hDEAD_BEEF);
    tick();
    check("word_ret_valid_end", ret_valid, 0);

    // Byte/half sizes and an unlisted type falling back to word
    issue(3'd0, 32'h0000_1003);
    check("byte_araddr", axi.araddr, 32'h0000_1003);
    check("byte_arsize", axi.arsize, 0);
    ar_accept();
    beat(32'h0000_0055, 1'b1, 2'b00);
    check("byte_ret_data", ret_data, 32'h55);
    issue(3'd1, 32'h0000_2002);
    check("half_arsize", axi.arsize, 1);
    check("half_arlen",  axi.arlen,  0);
    ar_accept();
    beat(32'h0000_6666, 1'b1, 2'b00);
    issue(3'd7, 32'h0000_300C);
    check("other_arsize", axi.arsize, 2);
    check("other_arlen",  axi.arlen,  0);
    check("other_araddr", axi.araddr, 32'h0000_300C);
    ar_accept();
    beat(32'h0000_7777, 1'b1, 2'b00);
    check("other_ret_last", ret_last, 1);
    tick();

    // Gapped beats: 3 idle cycles between beats 1 and 2
    issue(3'd4, 32'h0000_0040);
    check("gap_araddr", axi.araddr, 32'h0000_0040);
    ar_accept();
    beat(32'hB0, 1'b0, 2'b00);
    check("gap_ret_valid0", ret_valid, 1);
    check("gap_ret_data0",  ret_data,  32'hB0);
    beat(32'hB1, 1'b0, 2'b00);
    check("gap_ret_valid1", ret_valid, 1);
    check("gap_ret_data1",  ret_data,  32'hB1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("gap_idle%0d", i), ret_valid, 0);
      check($sformatf("gap_rready%0d", i), axi.rready, 1);
    end
    beat(32'hB2, 1'b0, 2'b00);
    check("gap_ret_valid2", ret_valid, 1);
    check("gap_ret_last2",  ret_last,  0);
    beat(32'hB3, 1'b1, 2'b00);
    check("gap_ret_valid3", ret_valid, 1);
    check("gap_ret_data3",  ret_data,  32'hB3);
    check("gap_ret_last3",  ret_last,  1);
    tick();
    check("gap_ret_valid_end", ret_valid, 0);
    check("gap_err",           err,       0);

    // Back-to-back: rd_req held high across the first transaction
    rd_req  = 1'b1;
    rd_type = 3'd2;
    rd_addr = 32'h0000_0100;
    tick();
    rd_addr = 32'h0000_0200;
    check("b2b_rd_rdy_busy", rd_rdy, 0);
    ar_accept();
    check("b2b_rd_rdy_r", rd_rdy, 0);
    beat(32'h11, 1'b1, 2'b00);
    check("b2b_ret_last",  ret_last,    1);
    check("b2b_ret_data",  ret_data,    32'h11);
    check("b2b_rd_rdy",    rd_rdy,      1);
    check("b2b_arvalid0",  axi.arvalid, 0);
    tick();
    rd_req = 1'b0;
    check("b2b_arvalid1",  axi.arvalid, 1);
    check("b2b_araddr1",   axi.araddr,  32'h0000_0200);
    check("b2b_ret_valid", ret_valid,   0);
    ar_accept();
    beat(32'h22, 1'b1, 2'b00);
    check("b2b_ret_data2", ret_data, 32'h22);
    tick();

    // Reset mid-burst after 2 beats
    issue(3'd4, 32'h0000_0080);
    ar_accept();
    beat(32'hC0, 1'b0, 2'b00);
    beat(32'hC1, 1'b0, 2'b00);
    reset      = 1'b1;
    axi.rvalid = 1'b1;
    axi.rdata  = 32'hC2;
    tick();
    reset = 1'b0;
    check("mid_rst_arvalid",   axi.arvalid, 0);
    check("mid_rst_rready",    axi.rready,  0);
    check("mid_rst_ret_valid", ret_valid,   0);
    check("mid_rst_rd_rdy",    rd_rdy,      1);
    axi.rdata = 32'hC3;
    tick();
    axi.rvalid = 1'b0;
    check("mid_rst_ignored", ret_valid, 0);
    check("mid_rst_data",    ret_data,  0);

    // rresp error on beat 2 of a line; data still forwarded, err sticky
    issue(3'd4, 32'h0000_00C0);
    ar_accept();
    beat(32'hD0, 1'b0, 2'b00);
    check("resp_err_before", err, 0);
    beat(32'hD1, 1'b0, 2'b10);
    check("resp_err_set",  err,      1);
    check("resp_data",     ret_data, 32'hD1);
    beat(32'hD2, 1'b0, 2'b00);
    beat(32'hD3, 1'b1, 2'b00);
    check("resp_ret_last", ret_last, 1);
    tick();
    tick();
    check("resp_err_sticky", err, 1);

    // Early rlast on beat 1 of a line
    do_reset();
    check("early_err_clr", err, 0);
    issue(3'd4, 32'h0000_0100);
    ar_accept();
    beat(32'hE0, 1'b1, 2'b00);
    check("early_ret_last", ret_last, 1);
    check("early_err",      err,      1);
    check("early_rd_rdy",   rd_rdy,   1);

    // Overrun: word read whose slave never asserts rlast
    do_reset();
    issue(3'd2, 32'h0000_0200);
    ar_accept();
    beat(32'hF0, 1'b0, 2'b00);
    check("ovr_last0", ret_last, 0);
    check("ovr_err0",  err,      0);
    check("ovr_busy",  rd_rdy,   0);
    beat(32'hF1, 1'b0, 2'b00);
    check("ovr_valid1", ret_valid, 1);
    check("ovr_data1",  ret_data,  32'hF1);
    check("ovr_last1",  ret_last,  1);
    check("ovr_err1",   err,       1);
    check("ovr_rd_rdy", rd_rdy,    1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- Read-side responder for the instruction cache refill interface: accepts one read request, issues it as an AXI4 read burst, and streams the returned beats back to the cache.
- Sits between the icache (rd_req/rd_type/rd_addr/rd_rdy, ret_valid/ret_last/ret_data) and the AXI read channels (AR/R).
- Single outstanding transaction; read-only, no write channels.

Parameters:
- ID_WIDTH, 4, width of arid/rid.
- AXI_ID, 0, constant ID driven on arid.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- rd_req  in  1  cache read request
- rd_type  in  3  0=byte, 1=half, 2=word, 4=16-byte line; any other value is handled as word
- rd_addr  in  32  request byte address
- rd_rdy  out  1  bridge can accept a request
- ret_valid  out  1  return beat valid
- ret_last  out  1  final beat of the transaction
- ret_data  out  32  return beat data
- err  out  1  sticky protocol/response error flag
- arid  out  ID_WIDTH  AR ID
- araddr  out  32  AR address
- arlen  out  8  AR burst length-1
- arsize  out  3  AR beat size
- arburst  out  2  AR burst type
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  ID_WIDTH  R ID (ignored)
- rdata  in  32  R data
- rresp  in  2  R response
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values:
  - state=IDLE.
  - arvalid, rready, ret_valid, ret_last, err = 0.
  - ret_data, latched address/type, beat count = 0.
  - rd_rdy = 1 from the first cycle after reset.
- Reset mid-transaction: abandon the transaction and return to IDLE; no further ret_valid is produced for it.
- States:
  - IDLE: rd_rdy=1. A request is accepted when rd_req && rd_rdy. Latch rd_addr and the normalised type; clear beat count; go to AR.
  - AR: arvalid=1, fields held stable from registers. On arready, go to R. arvalid rises the cycle after acceptance and stays high until arready.
  - R: rready=1 continuously, because the cache return path has no backpressure. Each cycle with rvalid is one beat:
    - Register ret_data<=rdata, ret_valid<=1, ret_last<=rlast, beat count++.
    - On the rlast beat, go to IDLE.
- Return timing:
  - ret_valid and ret_data appear exactly 1 cycle after the R handshake.
  - ret_valid is 0 in every cycle not following a beat.
  - Back-to-back beats produce back-to-back ret_valid.
- Overlap: the final ret_valid/ret_last pulse occurs in the first IDLE cycle. A new request may be accepted in that same cycle.
- AR field encoding:
  - Line (type 4): araddr={rd_addr[31:4],4'b0}, arlen=3, arsize=2.
  - Byte/half/word: araddr=rd_addr unmodified, arlen=0, arsize=type[1:0].
  - Word is used for any other rd_type value.
  - All requests: arburst=2'b01 (INCR), arid=AXI_ID.
- Error flag err: set and held until reset when any of the following occurs:
  - rresp != 0 on any beat.
  - rlast arrives on a beat other than beat arlen.
  - A beat would exceed arlen+1 without rlast.

  In the overrun case, the bridge forces ret_last=1 on that beat and returns to IDLE. Data is always forwarded regardless of err.
- Beat count width: 2 bits plus overflow detect; it wraps safely and never indexes out of range.
- Latency: a line hit on a zero-wait slave gives request accept → arvalid +1 → first ret_valid at arready+rvalid+1.

Test Plan:
- Line read: rd_type=4, rd_addr=0x1C00_0124, arready after 2 cycles, rdata 0xA0,0xA1,0xA2,0xA3 with rlast on the 4th → araddr=0x1C00_0120, arlen=3, arsize=2, arburst=1; four consecutive ret_valid with data A0..A3; ret_last only with A3; err=0; rd_rdy=1 afterwards.
- Word read: rd_type=2, rd_addr=0x8000_0004, single beat 0xDEADBEEF → arlen=0, arsize=2, araddr=0x8000_0004; one ret_valid with ret_last=1 and data DEADBEEF.
- Gapped beats: line read with rvalid idle for 3 cycles between beats 1 and 2 → ret_valid pulses mirror the gaps 1 cycle later; no spurious pulses.
- Back-to-back requests: rd_req held high → second request accepted in the cycle carrying the first ret_last; the second arvalid follows 1 cycle later.
- Error cases:
  - rresp=2 on beat 2 → err=1 and stays 1.
  - rlast on beat 1 of a line → err=1, state returns to IDLE.
- Reset mid-burst: assert reset after 2 beats → next cycle arvalid=0, rready=0, ret_valid=0, rd_rdy=1; further rvalid is ignored.
